// File: rtl/sccb_target.sv
// ---------------------------------------------------------------------------
// sccb_target
// SCCB/I2C responder standing in for a camera sensor's control port. Accepts
// 3-phase writes (ID, sub-address, data) and 2-phase reads (ID, data) into an
// internal 8-bit register file; a local port reads the register file back.
//
// Optional feature macro: SCCB_AUTOINC_EN (pointer auto-increment per byte).
//
// Ports
//   clk        system clock, at least 8x the SCL rate
//   resetn     asynchronous active-low reset
//   scl        SCCB clock from the master
//   sda        SCCB data, open-drain (drives 0 or z only)
//   loc_addr   local read address
//   loc_rdata  register-file data at loc_addr, one clk latency
//   wr_stb     one-clk pulse per committed SCCB data byte
//   wr_addr    sub-address of the committed byte
//   wr_data    committed byte
//   busy       high while this target is addressed, until STOP
// ---------------------------------------------------------------------------
module sccb_target #(
   parameter logic [6:0]  DEV_ID      = 7'h21,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] loc_addr,
   output logic [7:0] loc_rdata,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef SCCB_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and edge / bus-condition detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] scl_ff;
   logic [SYNC_STAGES-1:0] sda_ff;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;

   // Idle bus is high, so synchronisers reset to 1 to avoid false edges.
   always_ff @(posedge clk or negedge resetn) begin : sync_p
      if (!resetn) begin
         scl_ff <= '1;
         sda_ff <= '1;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
         sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
         scl_d  <= scl_s;
         sda_d  <= sda_s;
      end
   end

   assign scl_s     = scl_ff[SYNC_STAGES-1];
   assign sda_s     = sda_ff[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

   // ------------------------------------------------------------------
   // FSM / datapath registers
   // ------------------------------------------------------------------
   state_t     state_q,  state_n;
   logic [3:0] cnt_q,    cnt_n;
   logic [7:0] shreg_q,  shreg_n;
   logic [7:0] ptr_q,    ptr_n;
   logic       rw_q,     rw_n;
   logic       sda_oe_q, sda_oe_n;
   logic       busy_n;
   logic       wr_stb_n;
   logic [7:0] wr_addr_n;
   logic [7:0] wr_data_n;

   logic [7:0] mem [DEPTH];
   logic [7:0] rx_byte;
   logic [7:0] rd_byte;
   logic       ptr_ok;
   logic       loc_ok;

   // Range checks collapse to constant true for a full 256-entry file.
   if (DEPTH >= 256) begin : g_full
      assign ptr_ok = 1'b1;
      assign loc_ok = 1'b1;
   end else begin : g_part
      assign ptr_ok = (32'(ptr_q) < DEPTH);
      assign loc_ok = (32'(loc_addr) < DEPTH);
   end

   assign rx_byte = {shreg_q[6:0], sda_s};
   assign rd_byte = ptr_ok ? mem[AW'(ptr_q)] : 8'h00;

   // Open-drain pad; reset releases the line without waiting for a clock.
   assign sda = (sda_oe_q & resetn) ? 1'b0 : 1'bz;

   // State and output registers
   always_ff @(posedge clk or negedge resetn) begin : state_p
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         shreg_q  <= 8'h00;
         ptr_q    <= 8'h00;
         rw_q     <= 1'b0;
         sda_oe_q <= 1'b0;
         busy     <= 1'b0;
         wr_stb   <= 1'b0;
         wr_addr  <= 8'h00;
         wr_data  <= 8'h00;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         shreg_q  <= shreg_n;
         ptr_q    <= ptr_n;
         rw_q     <= rw_n;
         sda_oe_q <= sda_oe_n;
         busy     <= busy_n;
         wr_stb   <= wr_stb_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin : next_p
      state_n   = state_q;
      cnt_n     = cnt_q;
      shreg_n   = shreg_q;
      ptr_n     = ptr_q;
      rw_n      = rw_q;
      sda_oe_n  = sda_oe_q;
      busy_n    = busy;
      wr_stb_n  = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;

      if (stop_det) begin
         state_n  = IDLE;
         cnt_n    = 4'd0;
         sda_oe_n = 1'b0;
         busy_n   = 1'b0;
      end else if (start_det) begin
         // Any partial byte is simply dropped.
         state_n  = DEV_ADDR;
         cnt_n    = 4'd0;
         sda_oe_n = 1'b0;
      end else begin
         case (state_q)
            DEV_ADDR: begin
               if (scl_rise) begin
                  shreg_n = rx_byte;
                  cnt_n   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_n = 4'd0;
                     if (rx_byte[7:1] == DEV_ID) begin
                        state_n = DEV_ACK;
                        busy_n  = 1'b1;
                        rw_n    = rx_byte[0];
                     end else begin
                        state_n = IGNORE;
                        busy_n  = 1'b0;
                     end
                  end
               end
            end

            // ACK states: first SCL fall asserts the ACK, second ends it.
            DEV_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_n = 1'b1;
                  end else begin
                     cnt_n = 4'd0;
                     if (rw_q) begin
                        state_n  = RDATA;
                        shreg_n  = rd_byte;
                        sda_oe_n = ~rd_byte[7];
                        if (AUTOINC) ptr_n = ptr_q + 8'd1;
                     end else begin
                        state_n  = SUB_ADDR;
                        sda_oe_n = 1'b0;
                     end
                  end
               end
            end

            SUB_ADDR: begin
               if (scl_rise) begin
                  shreg_n = rx_byte;
                  cnt_n   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_n   = 4'd0;
                     ptr_n   = rx_byte;
                     state_n = SUB_ACK;
                  end
               end
            end

            SUB_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_n = 1'b1;
                  end else begin
                     sda_oe_n = 1'b0;
                     cnt_n    = 4'd0;
                     state_n  = WDATA;
                  end
               end
            end

            WDATA: begin
               if (scl_rise) begin
                  shreg_n = rx_byte;
                  cnt_n   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_n   = 4'd0;
                     state_n = WDATA_ACK;
                     // Out-of-range bytes are still ACKed but not committed.
                     if (ptr_ok) begin
                        wr_stb_n  = 1'b1;
                        wr_addr_n = ptr_q;
                        wr_data_n = rx_byte;
                     end
                     if (AUTOINC) ptr_n = ptr_q + 8'd1;
                  end
               end
            end

            // cnt counts master sampling edges; after the 8th the line is freed.
            RDATA: begin
               if (scl_rise) begin
                  cnt_n = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     cnt_n    = 4'd0;
                     sda_oe_n = 1'b0;
                     state_n  = RDATA_ACK;
                  end else begin
                     shreg_n  = {shreg_q[6:0], 1'b0};
                     sda_oe_n = ~shreg_q[6];
                  end
               end
            end

            // cnt==1 marks a master ACK seen on this clock's rising edge.
            RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_s) state_n = IGNORE;
                  else       cnt_n   = 4'd1;
               end else if (scl_fall && cnt_q == 4'd1) begin
                  cnt_n    = 4'd0;
                  state_n  = RDATA;
                  shreg_n  = rd_byte;
                  sda_oe_n = ~rd_byte[7];
                  if (AUTOINC) ptr_n = ptr_q + 8'd1;
               end
            end

            default: ;
         endcase
      end
   end

   // Register file
   always_ff @(posedge clk or negedge resetn) begin : mem_p
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else if (wr_stb_n) begin
         mem[AW'(ptr_q)] <= rx_byte;
      end
   end

   // Local read port, write-first on a same-cycle address collision
   always_ff @(posedge clk or negedge resetn) begin : loc_p
      if (!resetn) begin
         loc_rdata <= 8'h00;
      end else if (!loc_ok) begin
         loc_rdata <= 8'h00;
      end else if (wr_stb_n && (ptr_q == loc_addr)) begin
         loc_rdata <= rx_byte;
      end else begin
         loc_rdata <= mem[AW'(loc_addr)];
      end
   end

endmodule
